// File: rtl/piece_probe.sv
// piece_probe: sequential tetromino placement/collision probe against a 1-cycle board occupancy RAM.
// Define WALL_KICK_EN to enable three pivot-kick retries after a failed placement attempt.
module piece_probe #(
    parameter int BOARD_W = 10,
    parameter int BOARD_H = 22,
    parameter int POS_W   = 5,
    parameter int IDX_W   = 8,
    parameter int COLOR_W = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [2:0]         req_block,
    input  logic [1:0]         req_status,
    input  logic [POS_W-1:0]   req_x,
    input  logic [POS_W-1:0]   req_y,
    output logic               rd_en,
    output logic [IDX_W-1:0]   rd_addr,
    input  logic               rd_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_hit,
    output logic               rsp_oob,
    output logic [IDX_W-1:0]   rsp_pos0,
    output logic [IDX_W-1:0]   rsp_pos1,
    output logic [IDX_W-1:0]   rsp_pos2,
    output logic [IDX_W-1:0]   rsp_pos3,
    output logic [POS_W-1:0]   rsp_x,
    output logic [POS_W-1:0]   rsp_y,
    output logic [1:0]         rsp_kick,
    output logic [COLOR_W-1:0] rsp_color
);

    localparam int CW = POS_W + 2;
    typedef logic signed [CW-1:0] coord_t;

    localparam coord_t BW_S = coord_t'(BOARD_W);
    localparam coord_t BH_S = coord_t'(BOARD_H);

    // Piece codes; 3'd0 is not a piece and probes as fully out of bounds.
    localparam logic [2:0] BLOCK_I = 3'd1;
    localparam logic [2:0] BLOCK_J = 3'd2;
    localparam logic [2:0] BLOCK_L = 3'd3;
    localparam logic [2:0] BLOCK_O = 3'd4;
    localparam logic [2:0] BLOCK_S = 3'd5;
    localparam logic [2:0] BLOCK_T = 3'd6;
    localparam logic [2:0] BLOCK_Z = 3'd7;

    localparam logic [11:0] COLOR_I = 12'h0FF;
    localparam logic [11:0] COLOR_J = 12'h00F;
    localparam logic [11:0] COLOR_L = 12'hF80;
    localparam logic [11:0] COLOR_O = 12'hFF0;
    localparam logic [11:0] COLOR_S = 12'h0F0;
    localparam logic [11:0] COLOR_T = 12'h80F;
    localparam logic [11:0] COLOR_Z = 12'hF00;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_EVAL,
        S_RESP
    } state_t;

    function automatic void base_offset(input  logic [2:0]        b,
                                        input  logic [1:0]        j,
                                        output logic signed [2:0] dx,
                                        output logic signed [2:0] dy);
        dx = 3'sd0;
        dy = 3'sd0;
        case ({b, j})
            {BLOCK_I, 2'd1}: begin dx = -3'sd1; dy =  3'sd0; end
            {BLOCK_I, 2'd2}: begin dx =  3'sd1; dy =  3'sd0; end
            {BLOCK_I, 2'd3}: begin dx =  3'sd2; dy =  3'sd0; end
            {BLOCK_J, 2'd1}: begin dx = -3'sd1; dy =  3'sd1; end
            {BLOCK_J, 2'd2}: begin dx = -3'sd1; dy =  3'sd0; end
            {BLOCK_J, 2'd3}: begin dx =  3'sd1; dy =  3'sd0; end
            {BLOCK_L, 2'd1}: begin dx =  3'sd1; dy =  3'sd1; end
            {BLOCK_L, 2'd2}: begin dx = -3'sd1; dy =  3'sd0; end
            {BLOCK_L, 2'd3}: begin dx =  3'sd1; dy =  3'sd0; end
            {BLOCK_O, 2'd1}: begin dx =  3'sd0; dy =  3'sd1; end
            {BLOCK_O, 2'd2}: begin dx =  3'sd1; dy =  3'sd1; end
            {BLOCK_O, 2'd3}: begin dx =  3'sd1; dy =  3'sd0; end
            {BLOCK_S, 2'd1}: begin dx =  3'sd0; dy =  3'sd1; end
            {BLOCK_S, 2'd2}: begin dx =  3'sd1; dy =  3'sd1; end
            {BLOCK_S, 2'd3}: begin dx = -3'sd1; dy =  3'sd0; end
            {BLOCK_T, 2'd1}: begin dx =  3'sd0; dy =  3'sd1; end
            {BLOCK_T, 2'd2}: begin dx = -3'sd1; dy =  3'sd0; end
            {BLOCK_T, 2'd3}: begin dx =  3'sd1; dy =  3'sd0; end
            {BLOCK_Z, 2'd1}: begin dx = -3'sd1; dy =  3'sd1; end
            {BLOCK_Z, 2'd2}: begin dx =  3'sd0; dy =  3'sd1; end
            {BLOCK_Z, 2'd3}: begin dx =  3'sd1; dy =  3'sd0; end
            default: ;
        endcase
    endfunction

    // Each quarter turn clockwise maps (dx,dy) -> (dy,-dx).
    function automatic void rotate(input  logic [1:0]        s,
                                   input  logic signed [2:0] dx,
                                   input  logic signed [2:0] dy,
                                   output logic signed [2:0] rx,
                                   output logic signed [2:0] ry);
        case (s)
            2'd0:    begin rx =  dx; ry =  dy; end
            2'd1:    begin rx =  dy; ry = -dx; end
            2'd2:    begin rx = -dx; ry = -dy; end
            default: begin rx = -dy; ry =  dx; end
        endcase
    endfunction

    function automatic logic [COLOR_W-1:0] blk_color(input logic [2:0] b);
        logic [11:0] c;
        case (b)
            BLOCK_I: c = COLOR_I;
            BLOCK_J: c = COLOR_J;
            BLOCK_L: c = COLOR_L;
            BLOCK_O: c = COLOR_O;
            BLOCK_S: c = COLOR_S;
            BLOCK_T: c = COLOR_T;
            BLOCK_Z: c = COLOR_Z;
            default: c = '0;
        endcase
        return COLOR_W'(c);
    endfunction

    state_t             state_q;
    logic               req_ready_q;
    logic [2:0]         blk_q;
    logic [1:0]         st_q;
    logic [POS_W-1:0]   x_q;
    logic [POS_W-1:0]   y_q;
    coord_t             px_q;
    coord_t             py_q;
    logic [1:0]         k_q;
    logic               rd_en_q;
    logic [IDX_W-1:0]   rd_addr_q;
    logic               rd_vld_q;
    logic               occ_q;
    logic [3:0]         cell_oob_q;
    logic [IDX_W-1:0]   cell_idx_q [4];

    logic               rsp_valid_q;
    logic               rsp_hit_q;
    logic               rsp_oob_q;
    logic [IDX_W-1:0]   rsp_pos_q [4];
    logic [POS_W-1:0]   rsp_x_q;
    logic [POS_W-1:0]   rsp_y_q;
    logic [COLOR_W-1:0] rsp_color_q;

`ifdef WALL_KICK_EN
    logic [1:0]         cand_q;
    logic [1:0]         cand_d;
    logic               c0_oob_q;
    logic [IDX_W-1:0]   c0_pos_q [4];
    logic [1:0]         rsp_kick_q;
`endif

    // Next cell to issue: source selection, geometry and bounds.
    logic [2:0]         src_b;
    logic [1:0]         src_s;
    coord_t             src_x;
    coord_t             src_y;
    logic [1:0]         src_k;
    logic               issue_go;
    logic signed [2:0]  off_dx;
    logic signed [2:0]  off_dy;
    logic signed [2:0]  rot_dx;
    logic signed [2:0]  rot_dy;
    coord_t             cell_x;
    coord_t             cell_y;
    logic               cell_oob_d;
    logic [IDX_W-1:0]   cell_idx_d;
    logic               ev_hit;

    logic               rep_hit;
    logic               rep_oob;
    logic [IDX_W-1:0]   rep_pos [4];
    logic [POS_W-1:0]   rep_x;
    logic [POS_W-1:0]   rep_y;
    logic [1:0]         rep_kick;

    assign ev_hit = occ_q | (|cell_oob_q);

    always_comb begin
        src_b    = blk_q;
        src_s    = st_q;
        src_x    = px_q;
        src_y    = py_q;
        src_k    = k_q + 2'd1;
        issue_go = 1'b0;
`ifdef WALL_KICK_EN
        cand_d   = cand_q + 2'd1;
`endif
        case (state_q)
            S_IDLE: begin
                src_b    = req_block;
                src_s    = req_status;
                src_x    = coord_t'({2'b00, req_x});
                src_y    = coord_t'({2'b00, req_y});
                src_k    = 2'd0;
                issue_go = req_valid & req_ready_q;
            end
            S_ISSUE: issue_go = (k_q != 2'd3);
`ifdef WALL_KICK_EN
            // Retry pivots are offsets from the requested pivot, not cumulative.
            S_EVAL: begin
                src_k    = 2'd0;
                src_x    = coord_t'({2'b00, x_q});
                src_y    = coord_t'({2'b00, y_q});
                case (cand_d)
                    2'd1:    src_x = coord_t'({2'b00, x_q}) - coord_t'(1);
                    2'd2:    src_x = coord_t'({2'b00, x_q}) + coord_t'(1);
                    default: src_y = coord_t'({2'b00, y_q}) + coord_t'(1);
                endcase
                issue_go = ev_hit && (cand_q != 2'd3);
            end
`endif
            default: ;
        endcase

        base_offset(src_b, src_k, off_dx, off_dy);
        rotate(src_s, off_dx, off_dy, rot_dx, rot_dy);
        cell_x     = src_x + CW'(rot_dx);
        cell_y     = src_y + CW'(rot_dy);
        cell_oob_d = (src_b == 3'd0) || cell_x[CW-1] || cell_y[CW-1] ||
                     (cell_x >= BW_S) || (cell_y >= BH_S);
        cell_idx_d = cell_oob_d ? '0 :
                     IDX_W'(unsigned'(cell_y)) * IDX_W'(BOARD_W) + IDX_W'(unsigned'(cell_x));
    end

    always_comb begin
        rep_hit  = ev_hit;
        rep_oob  = |cell_oob_q;
        rep_pos  = cell_idx_q;
        rep_x    = x_q;
        rep_y    = y_q;
        rep_kick = 2'd0;
`ifdef WALL_KICK_EN
        if (!ev_hit) begin
            rep_x    = px_q[POS_W-1:0];
            rep_y    = py_q[POS_W-1:0];
            rep_kick = cand_q;
        end else begin
            rep_oob  = c0_oob_q;
            rep_pos  = c0_pos_q;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b1;
            blk_q       <= '0;
            st_q        <= '0;
            x_q         <= '0;
            y_q         <= '0;
            px_q        <= '0;
            py_q        <= '0;
            k_q         <= '0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            rd_vld_q    <= 1'b0;
            occ_q       <= 1'b0;
            cell_oob_q  <= '0;
            cell_idx_q  <= '{default: '0};
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_oob_q   <= 1'b0;
            rsp_pos_q   <= '{default: '0};
            rsp_x_q     <= '0;
            rsp_y_q     <= '0;
            rsp_color_q <= '0;
`ifdef WALL_KICK_EN
            cand_q      <= '0;
            c0_oob_q    <= 1'b0;
            c0_pos_q    <= '{default: '0};
            rsp_kick_q  <= '0;
`endif
        end else begin
            rd_vld_q <= rd_en_q;
            if (rd_vld_q) occ_q <= occ_q | rd_data;

            if (issue_go) begin
                rd_en_q           <= !cell_oob_d;
                rd_addr_q         <= cell_idx_d;
                cell_oob_q[src_k] <= cell_oob_d;
                cell_idx_q[src_k] <= cell_idx_d;
            end else begin
                rd_en_q   <= 1'b0;
                rd_addr_q <= '0;
            end

            case (state_q)
                S_IDLE: begin
                    if (req_valid && req_ready_q) begin
                        blk_q       <= req_block;
                        st_q        <= req_status;
                        x_q         <= req_x;
                        y_q         <= req_y;
                        px_q        <= src_x;
                        py_q        <= src_y;
                        k_q         <= 2'd0;
                        occ_q       <= 1'b0;
                        req_ready_q <= 1'b0;
                        state_q     <= S_ISSUE;
`ifdef WALL_KICK_EN
                        cand_q      <= 2'd0;
`endif
                    end
                end
                S_ISSUE: begin
                    k_q <= k_q + 2'd1;
                    if (k_q == 2'd3) state_q <= S_DRAIN;
                end
                S_DRAIN: state_q <= S_EVAL;
                S_EVAL: begin
                    if (issue_go) begin
`ifdef WALL_KICK_EN
                        if (cand_q == 2'd0) begin
                            c0_oob_q <= |cell_oob_q;
                            c0_pos_q <= cell_idx_q;
                        end
                        cand_q  <= cand_d;
                        px_q    <= src_x;
                        py_q    <= src_y;
                        k_q     <= 2'd0;
                        occ_q   <= 1'b0;
                        state_q <= S_ISSUE;
`endif
                    end else begin
                        rsp_hit_q   <= rep_hit;
                        rsp_oob_q   <= rep_oob;
                        rsp_pos_q   <= rep_pos;
                        rsp_x_q     <= rep_x;
                        rsp_y_q     <= rep_y;
                        rsp_color_q <= blk_color(blk_q);
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
`ifdef WALL_KICK_EN
                        rsp_kick_q  <= rep_kick;
`endif
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rd_en     = rd_en_q;
    assign rd_addr   = rd_addr_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_hit   = rsp_hit_q;
    assign rsp_oob   = rsp_oob_q;
    assign rsp_pos0  = rsp_pos_q[0];
    assign rsp_pos1  = rsp_pos_q[1];
    assign rsp_pos2  = rsp_pos_q[2];
    assign rsp_pos3  = rsp_pos_q[3];
    assign rsp_x     = rsp_x_q;
    assign rsp_y     = rsp_y_q;
    assign rsp_color = rsp_color_q;
`ifdef WALL_KICK_EN
    assign rsp_kick  = rsp_kick_q;
`else
    assign rsp_kick  = 2'd0;
    logic unused_rep_kick;
    assign unused_rep_kick = ^rep_kick;
`endif

endmodule

// File: tb/tb_piece_probe.sv
// Directed bench for piece_probe: hand-derived expectations queued at request time, checked on response.
module tb_piece_probe;

    localparam int BW = 10;
    localparam int BH = 22;
    localparam int PW = 5;
    localparam int IW = 8;
    localparam int CWD = 12;

    localparam logic [2:0] B_NONE = 3'd0;
    localparam logic [2:0] B_I = 3'd1;
    localparam logic [2:0] B_J = 3'd2;
    localparam logic [2:0] B_L = 3'd3;
    localparam logic [2:0] B_O = 3'd4;
    localparam logic [2:0] B_S = 3'd5;
    localparam logic [2:0] B_T = 3'd6;

    localparam int C_I = 12'h0FF;
    localparam int C_J = 12'h00F;
    localparam int C_L = 12'hF80;
    localparam int C_O = 12'hFF0;
    localparam int C_S = 12'h0F0;
    localparam int C_T = 12'h80F;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic           req_valid;
    logic           req_ready;
    logic [2:0]     req_block;
    logic [1:0]     req_status;
    logic [PW-1:0]  req_x;
    logic [PW-1:0]  req_y;
    logic           rd_en;
    logic [IW-1:0]  rd_addr;
    logic           rd_data = 1'b0;
    logic           rsp_valid;
    logic           rsp_ready;
    logic           rsp_hit;
    logic           rsp_oob;
    logic [IW-1:0]  rsp_pos0, rsp_pos1, rsp_pos2, rsp_pos3;
    logic [PW-1:0]  rsp_x, rsp_y;
    logic [1:0]     rsp_kick;
    logic [CWD-1:0] rsp_color;

    piece_probe #(.BOARD_W(BW), .BOARD_H(BH), .POS_W(PW), .IDX_W(IW), .COLOR_W(CWD)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_block(req_block), .req_status(req_status), .req_x(req_x), .req_y(req_y),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_hit(rsp_hit), .rsp_oob(rsp_oob),
        .rsp_pos0(rsp_pos0), .rsp_pos1(rsp_pos1), .rsp_pos2(rsp_pos2), .rsp_pos3(rsp_pos3),
        .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_kick(rsp_kick), .rsp_color(rsp_color)
    );

    // Board occupancy RAM with one-cycle read latency.
    logic occ_mem [256];
    always @(posedge clk) rd_data <= rd_en & occ_mem[rd_addr];

    int unsigned cyc = 0;
    int unsigned rd_cnt = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (rd_en) rd_cnt <= rd_cnt + 1;

    int unsigned checks = 0;
    int unsigned errors = 0;

    typedef struct {
        logic [2:0]  blk;
        logic [1:0]  st;
        logic [4:0]  x, y;
        logic        hit, oob;
        logic [7:0]  p0, p1, p2, p3;
        logic [4:0]  rx, ry;
        logic [1:0]  kick;
        logic [11:0] color;
        int unsigned lat, nrd;
    } exp_t;

    exp_t exp_q [$];

    function automatic exp_t mk(input logic [2:0] blk, input int st, input int x, input int y,
                                input int hit, input int oob,
                                input int p0, input int p1, input int p2, input int p3,
                                input int rx, input int ry, input int kick, input int color,
                                input int lat, input int nrd);
        exp_t e;
        e.blk = blk;          e.st = 2'(st);      e.x = 5'(x);        e.y = 5'(y);
        e.hit = 1'(hit);      e.oob = 1'(oob);
        e.p0 = 8'(p0);        e.p1 = 8'(p1);      e.p2 = 8'(p2);      e.p3 = 8'(p3);
        e.rx = 5'(rx);        e.ry = 5'(ry);      e.kick = 2'(kick);  e.color = 12'(color);
        e.lat = lat;          e.nrd = nrd;
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic run_probe(input exp_t e, input int hold, input bit overlap);
        exp_t        x;
        int unsigned acc_cyc, rd0;
        bit          seen;
        exp_q.push_back(e);
        @(negedge clk);
        check("idle_ready", req_ready, 1'b1);
        req_block = e.blk; req_status = e.st; req_x = e.x; req_y = e.y; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_block = ~e.blk; req_status = ~e.st; req_x = ~e.x; req_y = ~e.y;
        acc_cyc = cyc;
        rd0 = rd_cnt;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        x = exp_q.pop_front();
        check("rsp_timeout", seen, 1'b1);
        check("latency", cyc - acc_cyc, x.lat);
        check("rd_pulses", rd_cnt - rd0, x.nrd);
        check("busy_ready", req_ready, 1'b0);
        check("hit", rsp_hit, x.hit);
        check("oob", rsp_oob, x.oob);
        check("pos0", rsp_pos0, x.p0);
        check("pos1", rsp_pos1, x.p1);
        check("pos2", rsp_pos2, x.p2);
        check("pos3", rsp_pos3, x.p3);
        check("rsp_x", rsp_x, x.rx);
        check("rsp_y", rsp_y, x.ry);
        check("kick", rsp_kick, x.kick);
        check("color", rsp_color, x.color);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", rsp_valid, 1'b1);
            check("hold_ready", req_ready, 1'b0);
            check("hold_pos2", rsp_pos2, x.p2);
            check("hold_hit", rsp_hit, x.hit);
        end
        rsp_ready = 1'b1;
        if (overlap) begin
            req_block = B_T; req_status = 2'd0; req_x = 5'd4; req_y = 5'd4; req_valid = 1'b1;
        end
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        check("valid_drop", rsp_valid, 1'b0);
        check("ready_back", req_ready, 1'b1);
        if (overlap) check("no_same_cycle_probe", rd_en, 1'b0);
    endtask

    initial begin
        bit seen;
        for (int i = 0; i < 256; i++) occ_mem[i] = 1'b0;
        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        req_block = '0; req_status = '0; req_x = '0; req_y = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rd_en", rd_en, 1'b0);
        check("rst_rd_addr", rd_addr, 8'd0);
        check("rst_hit", rsp_hit, 1'b0);
        check("rst_pos0", rsp_pos0, 8'd0);
        check("rst_color", rsp_color, 12'd0);
        rst = 1'b0;

        // T, status 0, empty board: every cell in bounds.
        run_probe(mk(B_T, 0, 4, 10, 0, 0, 104, 114, 103, 105, 4, 10, 0, C_T, 6, 4), 0, 1'b0);

`ifdef WALL_KICK_EN
        run_probe(mk(B_I, 0, 8, 5, 0, 0, 57, 56, 58, 59, 7, 5, 1, C_I, 12, 7), 0, 1'b1);
        occ_mem[115] = 1'b1;
        run_probe(mk(B_J, 1, 4, 10, 0, 0, 103, 114, 113, 93, 3, 10, 1, C_J, 12, 8), 5, 1'b0);
        occ_mem[115] = 1'b0;
        run_probe(mk(B_O, 0, 9, 5, 0, 0, 58, 68, 69, 59, 8, 5, 1, C_O, 12, 6), 0, 1'b0);
        run_probe(mk(B_NONE, 0, 4, 10, 1, 1, 0, 0, 0, 0, 4, 10, 0, 0, 24, 0), 0, 1'b0);
        run_probe(mk(B_T, 2, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0, C_T, 24, 9), 0, 1'b0);
        run_probe(mk(B_S, 1, 9, 0, 1, 1, 9, 0, 0, 19, 9, 0, 0, C_S, 24, 7), 0, 1'b0);
`else
        run_probe(mk(B_I, 0, 8, 5, 1, 1, 58, 57, 59, 0, 8, 5, 0, C_I, 6, 3), 0, 1'b1);
        occ_mem[115] = 1'b1;
        run_probe(mk(B_J, 1, 4, 10, 1, 0, 104, 115, 114, 94, 4, 10, 0, C_J, 6, 4), 5, 1'b0);
        occ_mem[115] = 1'b0;
        run_probe(mk(B_O, 0, 9, 5, 1, 1, 59, 69, 0, 0, 9, 5, 0, C_O, 6, 2), 0, 1'b0);
        run_probe(mk(B_NONE, 0, 4, 10, 1, 1, 0, 0, 0, 0, 4, 10, 0, 0, 6, 0), 0, 1'b0);
        run_probe(mk(B_T, 2, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0, C_T, 6, 2), 0, 1'b0);
        run_probe(mk(B_S, 1, 9, 0, 1, 1, 9, 0, 0, 19, 9, 0, 0, C_S, 6, 2), 0, 1'b0);
`endif
        // L, status L, pivot near the top row: all cells on the board.
        run_probe(mk(B_L, 3, 5, 20, 0, 0, 205, 214, 195, 215, 5, 20, 0, C_L, 6, 4), 0, 1'b0);

        // Reset while cells are being issued aborts the probe.
        @(negedge clk);
        req_block = B_T; req_status = 2'd0; req_x = 5'd4; req_y = 5'd10; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("issue_rd_en", rd_en, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_rd_en", rd_en, 1'b0);
        check("abort_rsp_valid", rsp_valid, 1'b0);
        check("abort_req_ready", req_ready, 1'b1);
        check("abort_pos0", rsp_pos0, 8'd0);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        check("no_rsp_after_abort", seen, 1'b0);

        // Fresh probe after the abort still works.
        run_probe(mk(B_T, 0, 4, 10, 0, 0, 104, 114, 103, 105, 4, 10, 0, C_T, 6, 4), 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
